uart_io_buffer: RTL and testbench
=================================

Name: uart_io_buffer

Overview:
- Byte-buffered UART I/O unit for the core's IN/OUT instructions and the boot loader handshake.
- Owns one uart_rx, one uart_tx, and RX/TX ring FIFOs of parametrised depth.
- The execute stage talks to it through a req/ack handshake supporting byte and multi-byte word transfers; `busy` stalls the pipeline.

Parameters:
- CLK_PER_HALF_BIT, 434, baud divider passed to uart_rx/uart_tx.
- RX_AW, 11, log2 RX FIFO depth (capacity 2^RX_AW-1 bytes).
- TX_AW, 11, log2 TX FIFO depth (capacity 2^TX_AW-1 bytes).
- WORD_BYTES, 4, bytes per word transfer (1..4).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- rxd  in  1  UART serial input
- txd  out  1  UART serial output
- mode  in  3  1=LOAD handshake, 2=EXEC (RX capture enabled), others idle
- in_req  in  1  start IN transfer (1-cycle pulse)
- in_word  in  1  IN size: 0=byte, 1=WORD_BYTES bytes
- in_data  out  32  IN result
- in_ack  out  1  1-cycle pulse, in_data valid
- out_req  in  1  start OUT transfer (1-cycle pulse)
- out_word  in  1  OUT size: 0=byte, 1=word
- out_data  in  32  OUT payload, sampled on out_req
- out_ack  out  1  1-cycle pulse, last byte queued
- busy  out  1  combinational: (in_req|out_req) | fsm!=IDLE
- aa_received  out  1  pulse: rx byte == 8'hAA
- aa_sent  out  1  sticky: LOAD sync byte transmitted
- rx_overflow  out  1  sticky: RX byte dropped, FIFO full
- rx_count  out  RX_AW  bytes in RX FIFO
- tx_count  out  TX_AW  bytes in TX FIFO

Behaviour:
- Reset (async): all pointers 0. txd=1. in_data=0. in_ack=out_ack=aa_sent=rx_overflow=0. FSM=IDLE.
- FIFOs: power-of-two ring, pointers wrap naturally. Full when wptr+1==rptr; empty when wptr==rptr. Read data is available 1 cycle after address change (registered-RAM model).
- RX push: when mode==2 and rx_ready: write byte if not full, else drop it and set rx_overflow.
- aa_received: asserted in any mode, combinationally from rx_ready && byte==8'hAA.
- TX, mode==1: if !aa_sent, launch 8'hAA once. Set aa_sent when tx_busy falls after the launch. No FIFO drain in mode 1.
- TX drain, mode!=1: when !tx_busy, !tx_start and FIFO not empty: pop, wait for read latency, pulse tx_start one cycle with the byte. Minimum 1 idle cycle between bytes.
- FSM states: IDLE, RX_POP, RX_LAT, TX_PUSH, DONE.
  - IDLE: in_req → RX_POP, byte counter n=1 or WORD_BYTES. out_req → TX_PUSH, latch out_data/size. in_req and out_req in the same cycle: in_req wins, out_req dropped. Requests outside IDLE are ignored.
  - RX_POP: wait while RX FIFO empty (busy stays high), else pop → RX_LAT.
  - RX_LAT: shift byte in, accumulator <= {acc[23:0], byte}, so the first byte ends up most significant. Decrement n; n==0 → DONE, else RX_POP.
  - TX_PUSH: while FIFO full, hold. Else push the most significant remaining byte (byte mode: out_data[7:0]; word: byte WORD_BYTES-1 first), decrement n; n==0 → DONE.
  - DONE: single-cycle in_ack or out_ack. in_data updated same edge (upper bits zero for byte / WORD_BYTES<4). → IDLE.
- A pop and a push on the same FIFO in one cycle are both honoured; counts stay correct.
- mode change mid-transfer does not abort the FSM. Only reset aborts it, leaving pointers 0.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: uart_tx output feeds the uart_rx input internally; external rxd ignored; txd held 1. For self-test.
- Undefined: normal pins, no loopback logic present.

Test Plan:
- rstn low mid TX byte → txd=1 immediately, counts 0, aa_sent=0; release then mode=1 → one 0xAA frame on txd, aa_sent=1, no second frame.
- mode=2, serial 0x12,0x34,0x56,0x78 then in_req in_word=1 → in_ack once, in_data=0x12345678, rx_count=0.
- in_req byte with RX empty → busy held 1 for ≥1000 cycles; inject 0xAB → aa_received=0, in_data=0x000000AB, busy falls after ack.
- out_req word 0xDEADBEEF → out_ack, txd frames DE,AD,BE,EF in order; tx_count returns 0.
- Fill RX to 2^RX_AW-1 then send 0x55 → rx_overflow=1, rx_count unchanged, next reads return original data.
- TX_AW=2: out_req word with slow baud → FSM stalls in TX_PUSH at 3 bytes, completes after first frame drains; ordering intact.

Source files
------------

// File: rtl/uart_io_buffer_if.sv
// Execute-stage IN/OUT handshake bundle for uart_io_buffer.
interface uart_io_buffer_if;
  logic        in_req, in_word, in_ack;
  logic [31:0] in_data;
  logic        out_req, out_word, out_ack;
  logic [31:0] out_data;
  logic        busy;

  modport master (output in_req, in_word, out_req, out_word, out_data,
                  input  in_data, in_ack, out_ack, busy);
  modport slave  (input  in_req, in_word, out_req, out_word, out_data,
                  output in_data, in_ack, out_ack, busy);
endinterface

// File: rtl/uart_io_buffer.sv
// Byte-buffered UART I/O: uart_rx/uart_tx plus RX/TX ring FIFOs behind a req/ack port.
// Optional UART_LOOPBACK_EN: tx line drives rx internally, rxd ignored, txd held high.
module uart_tx #(parameter int CLK_PER_HALF_BIT = 434) (
  input  logic       clk, rstn, start,
  input  logic [7:0] data,
  output logic       txd, busy
);
  localparam int CW = $clog2(2*CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(2*CLK_PER_HALF_BIT-1);
  logic [9:0]    sh;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;

  assign txd = sh[0];

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sh <= '1; cnt <= '0; bitn <= '0; busy <= 1'b0;
    end else if (!busy) begin
      if (start) begin sh <= {1'b1, data, 1'b0}; cnt <= BIT_LAST; bitn <= '0; busy <= 1'b1; end
    end else if (cnt != '0) cnt <= cnt - CW'(1);
    else begin
      sh <= {1'b1, sh[9:1]}; cnt <= BIT_LAST; bitn <= bitn + 4'd1;
      if (bitn == 4'd9) busy <= 1'b0;
    end
endmodule

module uart_rx #(parameter int CLK_PER_HALF_BIT = 434) (
  input  logic       clk, rstn, rxd,
  output logic [7:0] data,
  output logic       ready
);
  localparam int CW = $clog2(2*CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(2*CLK_PER_HALF_BIT-1);
  localparam logic [CW-1:0] HALF     = CW'(CLK_PER_HALF_BIT-1);
  logic [1:0]    sync;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [7:0]    sh;

  // Start edge arms a half-bit wait so every later sample lands mid-bit.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync <= 2'b11; busy <= 1'b0; cnt <= '0; bitn <= '0; sh <= '0; data <= '0; ready <= 1'b0;
    end else begin
      sync  <= {sync[0], rxd};
      ready <= 1'b0;
      if (!busy) begin
        if (!sync[1]) begin busy <= 1'b1; cnt <= HALF; bitn <= '0; end
      end else if (cnt != '0) cnt <= cnt - CW'(1);
      else begin
        cnt <= BIT_LAST; bitn <= bitn + 4'd1;
        if (bitn == 4'd0) begin
          if (sync[1]) busy <= 1'b0;
        end else if (bitn <= 4'd8) sh <= {sync[1], sh[7:1]};
        else begin
          busy <= 1'b0;
          if (sync[1]) begin data <= sh; ready <= 1'b1; end
        end
      end
    end
endmodule

module uart_io_buffer #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int RX_AW            = 11,
  parameter int TX_AW            = 11,
  parameter int WORD_BYTES       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rxd,
  output logic             txd,
  input  logic [2:0]       mode,
  uart_io_buffer_if.slave  io,
  output logic             aa_received,
  output logic             aa_sent,
  output logic             rx_overflow,
  output logic [RX_AW-1:0] rx_count,
  output logic [TX_AW-1:0] tx_count
);
  typedef enum logic [2:0] {IDLE, RX_POP, RX_LAT, TX_PUSH, DONE} state_t;
  state_t      state;
  logic [2:0]  n;
  logic [23:0] acc;
  logic [31:0] obuf;
  logic [1:0]  bsel;
  logic [7:0]  push_byte, rx_byte, tx_byte;
  logic        rx_in, tx_line, rx_ready, tx_busy, tx_busy_d, tx_start, tx_pend, aa_launched;

  logic [7:0]       rx_mem [2**RX_AW];
  logic [7:0]       tx_mem [2**TX_AW];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [7:0]       rx_rd, tx_rd;
  logic             rx_full, rx_empty, rx_push, rx_pop, tx_full, tx_empty, tx_push, tx_pop;

`ifdef UART_LOOPBACK_EN
  wire unused_rxd = rxd;
  assign rx_in = tx_line;
  assign txd   = 1'b1;
`else
  assign rx_in = rxd;
  assign txd   = tx_line;
`endif

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .clk(clk), .rstn(rstn), .rxd(rx_in), .data(rx_byte), .ready(rx_ready));
  uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
    .clk(clk), .rstn(rstn), .start(tx_start), .data(tx_byte), .txd(tx_line), .busy(tx_busy));

  assign rx_full     = (rx_wp + RX_AW'(1)) == rx_rp;
  assign rx_empty    = rx_wp == rx_rp;
  assign tx_full     = (tx_wp + TX_AW'(1)) == tx_rp;
  assign tx_empty    = tx_wp == tx_rp;
  assign rx_count    = rx_wp - rx_rp;
  assign tx_count    = tx_wp - tx_rp;
  assign rx_push     = (mode == 3'd2) && rx_ready && !rx_full;
  assign rx_pop      = (state == RX_POP) && !rx_empty;
  assign tx_push     = (state == TX_PUSH) && !tx_full;
  assign tx_pop      = (mode != 3'd1) && !tx_busy && !tx_start && !tx_pend && !tx_empty;
  assign aa_received = rx_ready && (rx_byte == 8'hAA);
  assign io.busy     = io.in_req | io.out_req | (state != IDLE);
  assign bsel        = 2'(n - 3'd1);
  assign push_byte   = obuf[{bsel, 3'b000} +: 8];

  // Read port registers mem[rptr] every cycle, so a popped byte is valid the cycle after the pop.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_byte;
    if (tx_push) tx_mem[tx_wp] <= push_byte;
    rx_rd <= rx_mem[rx_rp];
    tx_rd <= tx_mem[tx_rp];
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rx_wp <= '0; rx_rp <= '0; tx_wp <= '0; tx_rp <= '0;
      rx_overflow <= 1'b0; aa_sent <= 1'b0; aa_launched <= 1'b0;
      tx_start <= 1'b0; tx_pend <= 1'b0; tx_busy_d <= 1'b0; tx_byte <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
      if ((mode == 3'd2) && rx_ready && rx_full) rx_overflow <= 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + RX_AW'(1);
      if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
      tx_start  <= 1'b0;
      tx_busy_d <= tx_busy;
      if (mode == 3'd1 && !aa_launched && !tx_busy && !tx_start && !tx_pend) begin
        tx_start <= 1'b1; tx_byte <= 8'hAA; aa_launched <= 1'b1;
      end
      if (tx_pend) begin
        tx_pend <= 1'b0; tx_start <= 1'b1; tx_byte <= tx_rd;
      end else if (tx_pop) begin
        tx_pend <= 1'b1; tx_rp <= tx_rp + TX_AW'(1);
      end
      if (aa_launched && tx_busy_d && !tx_busy) aa_sent <= 1'b1;
    end

  // Acks are raised on the edge entering DONE, so they are high exactly while in DONE.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE; n <= '0; acc <= '0; obuf <= '0;
      io.in_data <= '0; io.in_ack <= 1'b0; io.out_ack <= 1'b0;
    end else begin
      io.in_ack  <= 1'b0;
      io.out_ack <= 1'b0;
      case (state)
        IDLE:
          if (io.in_req) begin
            state <= RX_POP; acc <= '0;
            n <= io.in_word ? 3'(WORD_BYTES) : 3'd1;
          end else if (io.out_req) begin
            state <= TX_PUSH; obuf <= io.out_data;
            n <= io.out_word ? 3'(WORD_BYTES) : 3'd1;
          end
        RX_POP: if (!rx_empty) state <= RX_LAT;
        RX_LAT: begin
          acc <= {acc[15:0], rx_rd};
          n   <= n - 3'd1;
          if (n == 3'd1) begin
            state <= DONE; io.in_ack <= 1'b1; io.in_data <= {acc, rx_rd};
          end else state <= RX_POP;
        end
        TX_PUSH:
          if (!tx_full) begin
            n <= n - 3'd1;
            if (n == 3'd1) begin state <= DONE; io.out_ack <= 1'b1; end
          end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_io_buffer.sv
// Directed bench for uart_io_buffer: vector table of IN/OUT transfers plus reset, stall and overflow sequences.
module tb_uart_io_buffer;
  localparam int CPHB = 4, BIT = 2*CPHB, RX_AW = 3, TX_AW = 2, WB = 4;

  logic clk = 1'b0, rstn = 1'b0, rxd = 1'b1;
  logic txd, aa_received, aa_sent, rx_overflow;
  logic [2:0] mode = 3'd0;
  logic [RX_AW-1:0] rx_count;
  logic [TX_AW-1:0] tx_count;

  uart_io_buffer_if bus();

  uart_io_buffer #(.CLK_PER_HALF_BIT(CPHB), .RX_AW(RX_AW), .TX_AW(TX_AW), .WORD_BYTES(WB)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd), .mode(mode), .io(bus),
    .aa_received(aa_received), .aa_sent(aa_sent), .rx_overflow(rx_overflow),
    .rx_count(rx_count), .tx_count(tx_count));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int aa_cnt = 0, in_cnt = 0, out_cnt = 0;
  logic [31:0] in_last = '0;
  logic [7:0] tx_q[$];
  logic [7:0] mon_b;
  logic mon_ok;

  always @(negedge clk) begin
    if (aa_received) aa_cnt++;
    if (bus.in_ack) begin in_cnt++; in_last = bus.in_data; end
    if (bus.out_ack) out_cnt++;
  end

  // Serial decoder on txd; a frame cut by reset is discarded.
  task automatic mon_wait(input int n, inout logic ok);
    for (int i = 0; i < n && ok; i++) begin @(posedge clk); if (!rstn) ok = 1'b0; end
  endtask

  initial forever begin
    @(posedge clk);
    if (rstn && txd === 1'b0) begin
      mon_ok = 1'b1;
      mon_wait(BIT/2, mon_ok);
      for (int i = 0; i < 8; i++) begin mon_wait(BIT, mon_ok); mon_b[i] = txd; end
      mon_wait(BIT, mon_ok);
      if (mon_ok && txd) tx_q.push_back(mon_b);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s got=%h exp=%h", nm, got, exp); end
  endtask

  function automatic logic [31:0] qget(input int idx);
    return (idx < tx_q.size()) ? {24'h0, tx_q[idx]} : 32'hFFFF_FFFF;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rxd = 1'b0; repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (BIT) @(negedge clk); end
    rxd = 1'b1; repeat (2*BIT) @(negedge clk);
  endtask

  task automatic req(input logic i_r, input logic i_w, input logic o_r, input logic o_w, input logic [31:0] d);
    @(negedge clk);
    bus.in_req = i_r; bus.in_word = i_w; bus.out_req = o_r; bus.out_word = o_w; bus.out_data = d;
    @(negedge clk);
    bus.in_req = 1'b0; bus.out_req = 1'b0;
  endtask

  task automatic wait_ack(input string nm, input logic is_out, input int base, input int lim);
    int c;
    c = 0;
    while ((is_out ? out_cnt : in_cnt) == base && c < lim) begin @(negedge clk); c++; end
    chk(nm, ((is_out ? out_cnt : in_cnt) != base), 1);
  endtask

  task automatic wait_frames(input string nm, input int base, input int n, input int lim);
    int c;
    c = 0;
    while (tx_q.size() < base + n && c < lim) begin @(negedge clk); c++; end
    chk(nm, tx_q.size() - base, n);
  endtask

  typedef struct { logic is_out; logic word; logic [31:0] val; } vec_t;
  vec_t vt[6];
  logic [7:0] stall_exp[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nb, naa, a0, c0, q0, low, cyc;
    logic [7:0] bs[4];

    vt[0] = '{1'b0, 1'b1, 32'h12345678};
    vt[1] = '{1'b0, 1'b0, 32'h0000005A};
    vt[2] = '{1'b1, 1'b1, 32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b0, 32'h00000042};
    vt[4] = '{1'b0, 1'b1, 32'hA5C30F81};
    vt[5] = '{1'b0, 1'b0, 32'h000000AA};

    bus.in_req = 1'b0; bus.in_word = 1'b0; bus.out_req = 1'b0; bus.out_word = 1'b0; bus.out_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_in_data", bus.in_data, 0);
    chk("rst_acks", {bus.in_ack, bus.out_ack}, 0);
    chk("rst_sticky", {aa_sent, rx_overflow}, 0);
    chk("rst_counts", {rx_count, tx_count}, 0);
    chk("rst_busy", bus.busy, 0);

    // Reset in the middle of the LOAD sync frame
    rstn = 1'b1; @(negedge clk);
    mode = 3'd1;
    repeat (30) @(negedge clk);
    cyc = 0;
    while (txd && cyc < 20) begin @(negedge clk); cyc++; end
    chk("aa_midframe_low", txd, 0);
    rstn = 1'b0; #1;
    chk("rst_async_txd", txd, 1);
    chk("rst_async_aa_sent", aa_sent, 0);
    chk("rst_async_counts", {rx_count, tx_count}, 0);
    repeat (3) @(negedge clk);
    q0 = tx_q.size();
    rstn = 1'b1;
    repeat (300) @(negedge clk);
    chk("aa_frames", tx_q.size() - q0, 1);
    chk("aa_byte", qget(q0), 32'hAA);
    chk("aa_sent", aa_sent, 1);
    repeat (200) @(negedge clk);
    chk("aa_no_second", tx_q.size() - q0, 1);

    mode = 3'd2;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      nb = vt[k].word ? WB : 1;
      naa = 0;
      for (int j = 0; j < nb; j++) begin
        bs[j] = vt[k].val[8*(nb-1-j) +: 8];
        if (bs[j] == 8'hAA) naa++;
      end
      if (!vt[k].is_out) begin
        a0 = aa_cnt;
        for (int j = 0; j < nb; j++) send_byte(bs[j]);
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_rx_count", k), rx_count, nb);
        c0 = in_cnt;
        req(1'b1, vt[k].word, 1'b0, 1'b0, '0);
        wait_ack($sformatf("v%0d_in_ack", k), 1'b0, c0, 100);
        repeat (5) @(negedge clk);
        chk($sformatf("v%0d_in_data", k), in_last, vt[k].val);
        chk($sformatf("v%0d_ack_once", k), in_cnt - c0, 1);
        chk($sformatf("v%0d_rx_empty", k), rx_count, 0);
        chk($sformatf("v%0d_aa_rcv", k), aa_cnt - a0, naa);
      end else begin
        q0 = tx_q.size();
        c0 = out_cnt;
        req(1'b0, 1'b0, 1'b1, vt[k].word, vt[k].val);
        wait_ack($sformatf("v%0d_out_ack", k), 1'b1, c0, 100);
        wait_frames($sformatf("v%0d_frames", k), q0, nb, 2000);
        for (int j = 0; j < nb; j++) chk($sformatf("v%0d_txb%0d", k, j), qget(q0 + j), {24'h0, bs[j]});
        repeat (20) @(negedge clk);
        chk($sformatf("v%0d_tx_count", k), tx_count, 0);
      end
    end

    // IN byte with RX empty: stalls until a byte arrives
    c0 = in_cnt; a0 = aa_cnt; low = 0;
    req(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 1000; i++) begin @(negedge clk); if (!bus.busy) low++; end
    chk("empty_busy_low_cycles", low, 0);
    send_byte(8'hAB);
    wait_ack("ab_ack", 1'b0, c0, 200);
    @(negedge clk);
    chk("ab_data", in_last, 32'h000000AB);
    chk("ab_aa_rcv", aa_cnt - a0, 0);
    chk("ab_busy_after", bus.busy, 0);

    // Two words back to back: the second stalls in TX_PUSH on a full 3-entry FIFO
    q0 = tx_q.size(); c0 = out_cnt;
    req(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    wait_ack("w1_ack", 1'b1, c0, 100);
    c0 = out_cnt; cyc = 0;
    req(1'b0, 1'b0, 1'b1, 1'b1, 32'h01234567);
    while (out_cnt == c0 && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("w2_ack", out_cnt - c0, 1);
    chk("w2_stalled", (cyc > 40), 1);
    wait_frames("stall_frames", q0, 8, 3000);
    for (int j = 0; j < 8; j++) chk($sformatf("stall_b%0d", j), qget(q0 + j), {24'h0, stall_exp[j]});
    repeat (20) @(negedge clk);
    chk("stall_tx_count", tx_count, 0);

    // in_req and out_req together: IN wins, OUT dropped
    send_byte(8'h3C);
    q0 = tx_q.size(); c0 = in_cnt; a0 = out_cnt;
    req(1'b1, 1'b0, 1'b1, 1'b0, 32'h99);
    wait_ack("both_in_ack", 1'b0, c0, 100);
    chk("both_in_data", in_last, 32'h3C);
    repeat (200) @(negedge clk);
    chk("both_no_out_ack", out_cnt - a0, 0);
    chk("both_no_frame", tx_q.size() - q0, 0);
    chk("both_tx_count", tx_count, 0);

    // RX overflow at capacity 2^RX_AW-1
    for (int b = 1; b <= 7; b++) send_byte(8'(b));
    chk("ovf_full_count", rx_count, 7);
    chk("ovf_before", rx_overflow, 0);
    send_byte(8'h55);
    chk("ovf_set", rx_overflow, 1);
    chk("ovf_count_kept", rx_count, 7);
    c0 = in_cnt;
    req(1'b1, 1'b1, 1'b0, 1'b0, '0);
    wait_ack("ovf_word_ack", 1'b0, c0, 100);
    chk("ovf_word", in_last, 32'h01020304);
    for (int b = 5; b <= 7; b++) begin
      c0 = in_cnt;
      req(1'b1, 1'b0, 1'b0, 1'b0, '0);
      wait_ack($sformatf("ovf_b%0d_ack", b), 1'b0, c0, 100);
      chk($sformatf("ovf_b%0d", b), in_last, b);
    end
    repeat (3) @(negedge clk);
    chk("ovf_drained", rx_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
